bus_arbiter: RTL and testbench
==============================

// Module: bus_arbiter
// PURPOSE
//  Two-master arbiter in front of the Bridge/DRAM slave port. M0 = CPU data port, M1 = second
//  master (DMA / debug loader). One master owns the bus each cycle. The granted master's
//  addr/we/wdata drive the slave. Slave rdata goes back to both masters. A master holds its
//  request until granted (req && !gnt = stall).
// PARAMETERS
//  ADDR_W    32  address width, both masters and slave
//  DATA_W    32  data width; byte-enable width = DATA_W/8
//  MAX_HOLD  16  max consecutive granted cycles for the owner while the other master waits (>=1)
// PORTS
//  clk          in   1         clock; all state on rising edge
//  rst          in   1         asynchronous reset, active-high
//  m0_req       in   1         M0 requests an access this cycle
//  m0_addr      in   ADDR_W    M0 address
//  m0_we        in   DATA_W/8  M0 byte write enables
//  m0_wdata     in   DATA_W    M0 write data
//  m0_gnt       out  1         M0 access performed this cycle
//  m1_req/m1_addr/m1_we/m1_wdata/m1_gnt   same as M0, for M1
//  m_rdata      out  DATA_W    slave read data, broadcast; valid only with that master's gnt
//  s_addr       out  ADDR_W    to Bridge addr_from_cpu
//  s_we         out  DATA_W/8  to Bridge we_from_cpu
//  s_wdata      out  DATA_W    to Bridge wdata_from_cpu
//  s_rdata      in   DATA_W    from Bridge rdata_to_cpu (combinational read)
//  owner        out  1         current owner register (0=M0, 1=M1), for debug
// BEHAVIOUR
//  - State: owner (1b) plus hold_cnt ($clog2(MAX_HOLD+1) bits).
//    Reset: owner=0, hold_cnt=0. While rst is high: m0_gnt=m1_gnt=0, s_we=0.
//  - Grant is combinational from registered state: mX_gnt = (owner==X) & mX_req & !rst.
//    The parked owner sees zero-latency access. The non-owner waits >=1 cycle.
//  - Slave mux: s_addr/s_wdata follow owner. s_we = owner's we when its gnt=1, else 0.
//    A write with no grant never reaches DRAM.
//  - Next-state rules, evaluated each edge (O = owner, N = other):
//    a) O req & !N req: stay; hold_cnt=0 (no contention, no limit)
//    b) O req & N req & hold_cnt<MAX_HOLD-1: stay; hold_cnt++
//    c) O req & N req & hold_cnt==MAX_HOLD-1: owner<=N; hold_cnt=0 (O stalls next cycle)
//    d) !O req & N req: owner<=N; hold_cnt=0 (1-cycle handover)
//    e) neither req: stay (park); hold_cnt=0
//  - Fairness: under continuous contention, grants alternate in runs of MAX_HOLD cycles.
//    Worst-case wait = MAX_HOLD cycles. MAX_HOLD=1 gives strict alternation.
//  - hold_cnt saturates; never wraps.
//  - Inputs are not registered. rdata path adds no register; access latency = 0 after grant.
//  - Reset mid-run: grants and s_we drop immediately (async); owner returns to M0.
// CONFIGURATION
//  ARB_FIXED_PRIO_EN
//  - Defined: M0 has absolute priority.
//    - When M0 requests while M1 owns the bus, owner<=M0 at the next edge, regardless of hold_cnt.
//    - M0 is never hold-limited (rule c ignored for O=M0). M1 may starve; this is accepted.
//  - Undefined: round-robin rules a-e above.
// STRUCTURE
//  - Shared package bus_arb_pkg: localparams OWNER_M0=1'b0, OWNER_M1=1'b1,
//    HOLD_W=$clog2(MAX_HOLD+1) helper.
//  - One sub-module: arb_hold_cnt (saturating counter with clear/inc, async rst).
//    The mux and next-owner logic stay inline.
// TESTING
//  1 Reset, then M0 req only, addr 0x10 we=4'hF wdata=0xDEADBEEF
//    -> m0_gnt=1 same cycle, s_we=F, DRAM[4]=0xDEADBEEF; m1_gnt=0.
//  2 Owner M0 idle, M1 req read of 0x20
//    -> cycle0 m1_gnt=0, owner->1; cycle1 m1_gnt=1, m_rdata=DRAM[8].
//  3 Both req continuously, MAX_HOLD=4
//    -> gnt pattern M0x4, M1x4, M0x4...; no cycle with both gnt or neither gnt after cycle 0.
//  4 M1 owns, M1 req with we=F, M0 req with we=0
//    -> s_we=F only while m1_gnt. When M0 is granted, s_we=0 and no DRAM write from stalled M1.
//  5 Assert rst mid-contention (owner=M1, hold_cnt=2)
//    -> grants and s_we go 0 immediately; after release owner=0, hold_cnt=0.
//  6 ARB_FIXED_PRIO_EN, M1 owns, M0 raises req
//    -> next cycle m0_gnt=1. M0 req held 40 cycles -> m1_gnt stays 0 throughout.

Source files
------------

// File: rtl/bus_arb_pkg.sv
// ============================================================================
// Module   : bus_arb_pkg
// Brief    : Shared constants and helpers for the two-master bus arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bus_arb_pkg;

    // Owner encoding, also visible on the debug owner output
    localparam logic OWNER_M0 = 1'b0;
    localparam logic OWNER_M1 = 1'b1;

    // Width of a hold counter able to represent 0..max_hold
    function automatic int calc_hold_w(input int max_hold);
        return (max_hold < 1) ? 1 : $clog2(max_hold + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/arb_hold_cnt.sv
// ============================================================================
// Module   : arb_hold_cnt
// Brief    : Saturating up-counter with synchronous clear and increment,
//            asynchronous active-high reset. Clear wins over increment.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module arb_hold_cnt #(
    parameter int W   = 5,
    parameter int SAT = 16
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         i_clr,
    input  wire logic         i_inc,
    output logic [W-1:0]      o_cnt
);

    localparam logic [W-1:0] c_SAT = W'(SAT);

    logic [W-1:0] r_cnt;

    // Count contended cycles; hold at the ceiling instead of wrapping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != c_SAT)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

`default_nettype wire

// File: rtl/bus_arbiter.sv
// ============================================================================
// Module   : bus_arbiter
// Brief    : Two-master arbiter in front of the Bridge/DRAM slave port.
//            The parked owner gets zero-latency access; under contention the
//            owner yields after MAX_HOLD consecutive grants.
//            Build option ARB_FIXED_PRIO_EN: M0 takes absolute priority and
//            is never hold-limited (M1 may starve).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_HOLD = 16
) (
    input  wire logic                clk,
    input  wire logic                rst,
    input  wire logic                m0_req,
    input  wire logic [ADDR_W-1:0]   m0_addr,
    input  wire logic [DATA_W/8-1:0] m0_we,
    input  wire logic [DATA_W-1:0]   m0_wdata,
    output logic                     m0_gnt,
    input  wire logic                m1_req,
    input  wire logic [ADDR_W-1:0]   m1_addr,
    input  wire logic [DATA_W/8-1:0] m1_we,
    input  wire logic [DATA_W-1:0]   m1_wdata,
    output logic                     m1_gnt,
    output logic [DATA_W-1:0]        m_rdata,
    output logic [ADDR_W-1:0]        s_addr,
    output logic [DATA_W/8-1:0]      s_we,
    output logic [DATA_W-1:0]        s_wdata,
    input  wire logic [DATA_W-1:0]   s_rdata,
    output logic                     owner
);

    localparam int HOLD_W = calc_hold_w(MAX_HOLD);
    localparam int BE_W   = DATA_W / 8;

    logic              r_owner;
    logic              w_nxt_owner;
    logic              w_hold_clr;
    logic              w_hold_inc;
    logic [HOLD_W-1:0] w_hold_cnt;
    logic              w_own_req;
    logic              w_oth_req;
    logic              w_own_gnt;

    assign w_own_req = (r_owner == OWNER_M1) ? m1_req : m0_req;
    assign w_oth_req = (r_owner == OWNER_M1) ? m0_req : m1_req;

    // Grants come straight from the owner register so the parked owner
    // needs no arbitration cycle; reset kills them without waiting for clk.
    assign m0_gnt    = (r_owner == OWNER_M0) & m0_req & ~rst;
    assign m1_gnt    = (r_owner == OWNER_M1) & m1_req & ~rst;
    assign w_own_gnt = m0_gnt | m1_gnt;

    // Slave side follows the owner; a stalled master's write enables never
    // reach the slave.
    assign s_addr  = (r_owner == OWNER_M1) ? m1_addr  : m0_addr;
    assign s_wdata = (r_owner == OWNER_M1) ? m1_wdata : m0_wdata;
    assign s_we    = w_own_gnt ? ((r_owner == OWNER_M1) ? m1_we : m0_we) : {BE_W{1'b0}};
    assign m_rdata = s_rdata;
    assign owner   = r_owner;

`ifdef ARB_FIXED_PRIO_EN
    // Next owner: M0 always wins when requesting; otherwise hand to a lone M1
    always_comb begin
        w_nxt_owner = r_owner;
        w_hold_clr  = 1'b1;
        w_hold_inc  = 1'b0;
        if (m0_req) begin
            w_nxt_owner = OWNER_M0;
            if ((r_owner == OWNER_M0) && m1_req) begin
                w_hold_clr = 1'b0;
                w_hold_inc = 1'b1;
            end
        end else if (m1_req) begin
            w_nxt_owner = OWNER_M1;
        end
    end
`else
    localparam logic [HOLD_W-1:0] c_HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    // Next owner: keep the bus under contention until the hold limit, hand
    // over immediately when the owner goes quiet and the other master asks.
    always_comb begin
        w_nxt_owner = r_owner;
        w_hold_clr  = 1'b1;
        w_hold_inc  = 1'b0;
        if (w_own_req && w_oth_req) begin
            if (w_hold_cnt >= c_HOLD_LAST) begin
                w_nxt_owner = ~r_owner;
            end else begin
                w_hold_clr = 1'b0;
                w_hold_inc = 1'b1;
            end
        end else if (w_oth_req) begin
            w_nxt_owner = ~r_owner;
        end
    end
`endif

    // Owner register; reset parks the bus on M0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner <= OWNER_M0;
        end else begin
            r_owner <= w_nxt_owner;
        end
    end

    arb_hold_cnt #(
        .W   (HOLD_W),
        .SAT (MAX_HOLD)
    ) u_hold_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_hold_clr),
        .i_inc (w_hold_inc),
        .o_cnt (w_hold_cnt)
    );

endmodule

`default_nettype wire

// File: tb/tb_bus_arbiter.sv
// ============================================================================
// Module   : tb_bus_arbiter
// Brief    : Self-checking bench for bus_arbiter with a DRAM model on the
//            slave port and a behavioural arbitration model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bus_arbiter;

    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int BE_W     = DATA_W / 8;
    localparam int MAX_HOLD = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              m0_req, m1_req;
    logic [ADDR_W-1:0] m0_addr, m1_addr;
    logic [BE_W-1:0]   m0_we, m1_we;
    logic [DATA_W-1:0] m0_wdata, m1_wdata;
    logic              m0_gnt, m1_gnt;
    logic [DATA_W-1:0] m_rdata;
    logic [ADDR_W-1:0] s_addr;
    logic [BE_W-1:0]   s_we;
    logic [DATA_W-1:0] s_wdata;
    logic [DATA_W-1:0] s_rdata;
    logic              owner;

    int tests = 0;
    int fails = 0;

    bus_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .m0_req   (m0_req),
        .m0_addr  (m0_addr),
        .m0_we    (m0_we),
        .m0_wdata (m0_wdata),
        .m0_gnt   (m0_gnt),
        .m1_req   (m1_req),
        .m1_addr  (m1_addr),
        .m1_we    (m1_we),
        .m1_wdata (m1_wdata),
        .m1_gnt   (m1_gnt),
        .m_rdata  (m_rdata),
        .s_addr   (s_addr),
        .s_we     (s_we),
        .s_wdata  (s_wdata),
        .s_rdata  (s_rdata),
        .owner    (owner)
    );

    always #5 clk = ~clk;

    // DRAM model: 256 words, combinational read, byte-enabled write
    logic [31:0] mem [0:255];
    assign s_rdata = mem[s_addr[9:2]];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'hA500_0000 | 32'(i);
        end else begin
            for (int b = 0; b < BE_W; b++)
                if (s_we[b]) mem[s_addr[9:2]][b*8 +: 8] <= s_wdata[b*8 +: 8];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: who owns the bus, and how many contended grants the
    // owner has already had in its current run.
    logic m_owner;
    int   m_run;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_owner <= 1'b0;
            m_run   <= 0;
        end else begin
`ifdef ARB_FIXED_PRIO_EN
            if (m0_req)      m_owner <= 1'b0;
            else if (m1_req) m_owner <= 1'b1;
            m_run <= 0;
`else
            if (m0_req && m1_req) begin
                if (m_run + 1 >= MAX_HOLD) begin
                    m_owner <= ~m_owner;
                    m_run   <= 0;
                end else begin
                    m_run <= m_run + 1;
                end
            end else begin
                if ((m_owner ? m0_req : m1_req)) m_owner <= ~m_owner;
                m_run <= 0;
            end
`endif
        end
    end

    // Compare DUT outputs against the model every cycle, mid-cycle
    logic              e_g0, e_g1;
    logic [ADDR_W-1:0] e_addr;
    logic [BE_W-1:0]   e_we;
    logic [DATA_W-1:0] e_wdata;

    always @(negedge clk) begin
        if (rst) begin
            check("rst_m0_gnt", m0_gnt, 0);
            check("rst_m1_gnt", m1_gnt, 0);
            check("rst_s_we", s_we, 0);
        end else begin
            e_g0    = !m_owner && m0_req;
            e_g1    = m_owner && m1_req;
            e_addr  = m_owner ? m1_addr : m0_addr;
            e_wdata = m_owner ? m1_wdata : m0_wdata;
            e_we    = (e_g0 || e_g1) ? (m_owner ? m1_we : m0_we) : '0;
            check("cmp_owner", owner, m_owner);
            check("cmp_m0_gnt", m0_gnt, e_g0);
            check("cmp_m1_gnt", m1_gnt, e_g1);
            check("cmp_s_addr", s_addr, e_addr);
            check("cmp_s_wdata", s_wdata, e_wdata);
            check("cmp_s_we", s_we, e_we);
            if (e_g0 || e_g1) check("cmp_rdata", m_rdata, mem[e_addr[9:2]]);
        end
    end

    task automatic drive(input logic r0, input logic [31:0] a0, input logic [3:0] w0,
                         input logic [31:0] d0, input logic r1, input logic [31:0] a1,
                         input logic [3:0] w1, input logic [31:0] d1);
        m0_req = r0; m0_addr = a0; m0_we = w0; m0_wdata = d0;
        m1_req = r1; m1_addr = a1; m1_we = w1; m1_wdata = d1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    int m1_cnt;

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        do_reset();
        @(negedge clk);
        check("reset_owner", owner, 0);
        check("reset_m0_gnt", m0_gnt, 0);

        // 1: M0 alone writes, zero-latency grant
        next_cycle();
        drive(1, 32'h10, 4'hF, 32'hDEADBEEF, 0, 0, 0, 0);
        @(negedge clk);
        check("t1_m0_gnt", m0_gnt, 1);
        check("t1_m1_gnt", m1_gnt, 0);
        check("t1_s_we", s_we, 4'hF);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("t1_dram4", mem[4], 32'hDEADBEEF);

        // 2: M1 read while M0 parked: one handover cycle
        next_cycle();
        drive(0, 0, 0, 0, 1, 32'h20, 4'h0, 0);
        @(negedge clk);
        check("t2_c0_m1_gnt", m1_gnt, 0);
        next_cycle();
        @(negedge clk);
        check("t2_c1_m1_gnt", m1_gnt, 1);
        check("t2_c1_owner", owner, 1);
        check("t2_c1_rdata", m_rdata, 32'hA500_0008);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);

`ifndef ARB_FIXED_PRIO_EN
        // 3: continuous contention alternates in runs of MAX_HOLD
        do_reset();
        drive(1, 32'h30, 0, 0, 1, 32'h34, 0, 0);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            check("t3_m0_gnt", m0_gnt, ((c / 4) % 2) == 0);
            check("t3_m1_gnt", m1_gnt, ((c / 4) % 2) == 1);
            next_cycle();
        end

        // 4: stalled writer never reaches DRAM
        drive(0, 0, 0, 0, 1, 32'h40, 4'hF, 32'h1111_1111);
        next_cycle();
        next_cycle();
        drive(1, 32'h44, 4'h0, 0, 1, 32'h40, 4'hF, 32'h1111_1111);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c < 4) check("t4_m1_we", s_we, 4'hF);
            else       check("t4_m0_we", s_we, 4'h0);
            next_cycle();
            if (c == 3) m1_wdata = 32'h2222_2222;
        end
        @(negedge clk);
        check("t4_dram16", mem[16], 32'h1111_1111);
        check("t4_m1_back", m1_gnt, 1);

        // 5: async reset mid-contention with owner=M1, hold_cnt=2
        do_reset();
        drive(1, 32'h50, 4'h0, 0, 1, 32'h54, 4'hF, 32'h3333_3333);
        for (int c = 0; c < 6; c++) next_cycle();
        @(negedge clk);
        check("t5_pre_m1_gnt", m1_gnt, 1);
        #1 rst = 1'b1;
        #1;
        check("t5_m0_gnt", m0_gnt, 0);
        check("t5_m1_gnt", m1_gnt, 0);
        check("t5_s_we", s_we, 0);
        check("t5_owner", owner, 0);
        next_cycle();
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("t5_run_m0", m0_gnt, c < 4);
            next_cycle();
        end
`else
        // 6: M0 preempts M1 and then keeps the bus
        do_reset();
        drive(0, 0, 0, 0, 1, 32'h60, 0, 0);
        next_cycle();
        drive(1, 32'h64, 0, 0, 1, 32'h60, 0, 0);
        @(negedge clk);
        check("t6_c0_m1_gnt", m1_gnt, 1);
        next_cycle();
        @(negedge clk);
        check("t6_c1_m0_gnt", m0_gnt, 1);
        m1_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (m1_gnt) m1_cnt++;
            next_cycle();
        end
        check("t6_m1_starved", m1_cnt, 0);
`endif

        // Random traffic against the model, with occasional async resets
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            drive($urandom_range(0, 9) < 7, {24'h0, 6'($urandom), 2'b00}, 4'($urandom), $urandom,
                  $urandom_range(0, 9) < 7, {24'h0, 6'($urandom), 2'b00}, 4'($urandom), $urandom);
            if ($urandom_range(0, 299) == 0) begin
                rst = 1'b1;
                #2 rst = 1'b0;
            end
            next_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
